// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// The state encodings are exported so a debug probe can decode the FSM.
package imem_boot_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;

    typedef enum logic [2:0] {
        IMEM_BOOT_IDLE  = 3'd0,
        IMEM_BOOT_LOAD  = 3'd1,
        IMEM_BOOT_DRAIN = 3'd2,
        IMEM_BOOT_DONE  = 3'd3,
        IMEM_BOOT_ERR   = 3'd4
    } boot_state_e;

    // Widened to 64 bits so base+len cannot wrap for any ADDR_W up to 63.
    function automatic logic img_in_range(input logic [63:0] base,
                                          input logic [63:0] len,
                                          input logic [63:0] depth);
        return (base < depth) && ((base + len) <= depth);
    endfunction

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot-load sequencer: streams words into the instruction memory write port
// from a programmable base and stalls the CPU until the image is complete.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int ADDR_W        = ADDR_LEN,
    parameter int DATA_W        = INST_LEN,
    parameter int DEPTH         = 4096,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, len_q, count_q;
    logic              hold_d;
    logic              range_ok, start_ok, beat, last_beat;

    assign range_ok  = img_in_range(64'(base_i), 64'(len_i), 64'(DEPTH));
    assign start_ok  = start_i && (state_q inside {IMEM_BOOT_IDLE, IMEM_BOOT_DONE, IMEM_BOOT_ERR});

    // Abort masks ready so a word offered alongside it is never consumed.
    assign ld_ready_o = (state_q == IMEM_BOOT_LOAD) && !abort_i;
    assign beat       = ld_valid_i && ld_ready_o;
    assign last_beat  = beat && (count_q == (len_q - ADDR_W'(1)));

    assign busy_o = (state_q == IMEM_BOOT_LOAD) || (state_q == IMEM_BOOT_DRAIN);
    assign done_o = (state_q == IMEM_BOOT_DONE);
    assign err_o  = (state_q == IMEM_BOOT_ERR);

    always_comb begin
        state_d = state_q;
        hold_d  = cpu_hold_o;
        case (state_q)
            IMEM_BOOT_IDLE, IMEM_BOOT_DONE, IMEM_BOOT_ERR: begin
                if (start_i) begin
                    if (len_i == '0)
                        state_d = IMEM_BOOT_DONE;
                    else if (!range_ok)
                        state_d = IMEM_BOOT_ERR;
                    else
                        state_d = IMEM_BOOT_LOAD;
                end
            end
            IMEM_BOOT_LOAD: begin
                if (abort_i)
                    state_d = IMEM_BOOT_IDLE;
                else if (last_beat)
                    state_d = IMEM_BOOT_DRAIN;
            end
            IMEM_BOOT_DRAIN: state_d = IMEM_BOOT_DONE;
            default:         state_d = IMEM_BOOT_IDLE;
        endcase

        // Hold drops only on entry to DONE; an aborted load keeps the core stalled.
        if (state_d == IMEM_BOOT_DONE)
            hold_d = 1'b0;
        else if (start_ok || (state_d inside {IMEM_BOOT_LOAD, IMEM_BOOT_DRAIN, IMEM_BOOT_ERR}))
            hold_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IMEM_BOOT_IDLE;
            cpu_hold_o <= HOLD_ON_RESET;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cpu_hold_o <= hold_d;
            if (start_ok) begin
                base_q  <= base_i;
                len_q   <= len_i;
                count_q <= '0;
            end else if (beat) begin
                count_q <= count_q + ADDR_W'(1);
            end
        end
    end

    // One-cycle write register: a beat in cycle N is written in cycle N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen_o   <= 1'b1;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_wen_o <= !beat;
            if (beat) begin
                mem_waddr_o <= base_q + count_q;
                mem_wdata_o <= ld_data_i;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl against a per-load cycle-expectation model.
module tb_imem_boot_ctrl;
    import imem_boot_ctrl_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int NC    = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] base_i = '0;
    logic [AW-1:0] len_i = '0;
    logic          ld_valid_i = 1'b0;
    logic [DW-1:0] ld_data_i = '0;
    logic          ld_ready_o, mem_wen_o, cpu_hold_o, busy_o, done_o, err_o;
    logic [AW-1:0] mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    imem_boot_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .HOLD_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .base_i(base_i), .len_i(len_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_ready_o(ld_ready_o), .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o), .cpu_hold_o(cpu_hold_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One load transaction. Expectations are built from the handshake rules:
    // ready in every load cycle until the len-th beat, each beat written one
    // cycle later at base+index, one drain cycle, then done with hold released.
    task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [15:0] pat, input int patlen, input int vpct,
                            input int abort_c, input int start_c, input bit ab_with_start,
                            input string nm);
        logic          v[NC], ab[NC], st[NC];
        logic [DW-1:0] d[NC], ed[NC];
        logic [AW-1:0] ea[NC];
        logic          er[NC], ew[NC], eb[NC], edn[NC], eh[NC], ee[NC];
        logic [63:0]   sum;
        int            mode, acc;   // 0 load, 1 drain, 2 done, 3 idle, 4 err
        for (int c = 0; c < NC; c++) begin
            if (c < patlen)  v[c] = pat[c];
            else if (c >= 20) v[c] = 1'b1;
            else             v[c] = (int'($urandom_range(99)) < vpct);
            d[c]  = $urandom;
            ab[c] = (c == abort_c);
            st[c] = 1'b0;
            ew[c] = 1'b0;
            ea[c] = '0;
            ed[c] = '0;
        end
        sum = 64'(base) + 64'(len);
        if (len == '0)                            mode = 2;
        else if (base >= DEPTH || sum > DEPTH)    mode = 4;
        else                                      mode = 0;
        acc = 0;
        for (int c = 0; c < NC; c++) begin
            er[c] = 0; eb[c] = 0; edn[c] = 0; ee[c] = 0; eh[c] = 1;
            case (mode)
                0: begin
                    eb[c] = 1; er[c] = !ab[c]; st[c] = (c == start_c);
                    if (ab[c]) mode = 3;
                    else if (v[c]) begin
                        if (c + 1 < NC) begin
                            ew[c+1] = 1; ea[c+1] = base + AW'(acc); ed[c+1] = d[c];
                        end
                        acc++;
                        if (acc == int'(len)) mode = 1;
                    end
                end
                1: begin eb[c] = 1; st[c] = (c == start_c); mode = 2; end
                2: begin edn[c] = 1; eh[c] = 0; end
                4: ee[c] = 1;
                default: ;
            endcase
        end

        @(negedge clk);
        start_i = 1'b1; base_i = base; len_i = len; abort_i = ab_with_start; ld_valid_i = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            start_i = st[c];
            if (st[c]) begin base_i = $urandom; len_i = '0; end
            abort_i = ab[c]; ld_valid_i = v[c]; ld_data_i = d[c];
            #1;
            chk({nm, "/ready"}, ld_ready_o, er[c]);
            chk({nm, "/wen"},   mem_wen_o, !ew[c]);
            if (ew[c]) begin
                chk({nm, "/waddr"}, mem_waddr_o, ea[c]);
                chk({nm, "/wdata"}, mem_wdata_o, ed[c]);
            end
            chk({nm, "/busy"}, busy_o, eb[c]);
            chk({nm, "/done"}, done_o, edn[c]);
            chk({nm, "/err"},  err_o,  ee[c]);
            chk({nm, "/hold"}, cpu_hold_o, eh[c]);
        end
        start_i = 1'b0; abort_i = 1'b0; ld_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] b, l;
        int r;
        #12;
        chk("rst/hold",  cpu_hold_o, 1'b1);
        chk("rst/wen",   mem_wen_o, 1'b1);
        chk("rst/ready", ld_ready_o, 1'b0);
        chk("rst/busy",  busy_o, 1'b0);
        chk("rst/done",  done_o, 1'b0);
        chk("rst/err",   err_o, 1'b0);
        chk("rst/waddr", mem_waddr_o, '0);
        chk("rst/wdata", mem_wdata_o, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_load(32'h10, 32'd4, 16'hffff, 16, 100, -1, -1, 1'b0, "burst");
        run_load(32'h10, 32'd4, 16'b1011001, 7, 0, -1, -1, 1'b0, "gapped");
        run_load(32'd4090, 32'd7, 16'h0, 0, 100, -1, -1, 1'b0, "ovf");
        run_load(32'd4090, 32'd6, 16'h0, 0, 100, -1, -1, 1'b1, "edge");
        run_load(32'd5000, 32'd1, 16'h0, 0, 100, -1, -1, 1'b0, "base_oor");
        run_load(32'hffff_fff0, 32'h20, 16'h0, 0, 100, -1, -1, 1'b0, "wrap");
        run_load(32'h20, 32'd0, 16'h0, 0, 100, -1, -1, 1'b0, "len0");
        run_load(32'h40, 32'd6, 16'h0, 0, 70, -1, 2, 1'b0, "start_in_load");
        run_load(32'h80, 32'd5, 16'hffff, 16, 100, 2, -1, 1'b0, "abort");
        run_load(32'h90, 32'd3, 16'hffff, 16, 100, 3, -1, 1'b0, "abort_drain");

        // Asynchronous reset in the middle of a load.
        @(negedge clk);
        start_i = 1'b1; base_i = 32'h100; len_i = 32'd6;
        @(negedge clk);
        start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = $urandom;
        @(negedge clk);
        ld_data_i = $urandom;
        #1;
        chk("midrst/wen_before", mem_wen_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst/wen",   mem_wen_o, 1'b1);
        chk("midrst/ready", ld_ready_o, 1'b0);
        chk("midrst/busy",  busy_o, 1'b0);
        chk("midrst/hold",  cpu_hold_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; ld_valid_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(9));
            l = $urandom_range(8);
            if (r < 6)      b = $urandom_range(DEPTH - 9);
            else if (r < 8) b = DEPTH - $urandom_range(10);
            else            b = $urandom;
            run_load(b, l, 16'h0, 0, int'($urandom_range(90, 30)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1,
                     ($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1,
                     1'($urandom_range(1)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
